apb_master: RTL and testbench



---
 rtl/apb_pkg.sv | 39 +++
 rtl/apb_master_if.sv | 43 ++++
 rtl/apb_timeout_cnt.sv | 35 +++
 rtl/apb_master.sv | 118 +++++++++++
 tb/tb_apb_master.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : apb_pkg
// Brief   : Shared types and constants for the APB initiator and its users:
//           FSM state encoding, default bus widths, rotator register map.
// Revision: 1.0 - initial release
// ============================================================================
package apb_pkg;

  // Transfer phases of the APB initiator
  typedef enum logic [1:0] {
    APB_IDLE   = 2'd0,
    APB_SETUP  = 2'd1,
    APB_ACCESS = 2'd2
  } apb_state_e;

  // Default bus widths
  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  // Rotator register-file byte offsets
  localparam logic [31:0] REG_DMA_SRC    = 32'h00;
  localparam logic [31:0] REG_DMA_DST    = 32'h04;
  localparam logic [31:0] REG_IMG_H      = 32'h08;
  localparam logic [31:0] REG_IMG_W      = 32'h0C;
  localparam logic [31:0] REG_NEW_H      = 32'h10;
  localparam logic [31:0] REG_NEW_W      = 32'h14;
  localparam logic [31:0] REG_MODE       = 32'h18;
  localparam logic [31:0] REG_DIR        = 32'h1C;
  localparam logic [31:0] REG_START      = 32'h20;
  localparam logic [31:0] REG_RESET      = 32'h24;
  localparam logic [31:0] REG_INTR_MASK  = 32'h28;
  localparam logic [31:0] REG_BEF_MASK   = 32'h2C;
  localparam logic [31:0] REG_AFT_MASK   = 32'h30;
  localparam logic [31:0] REG_INTR_CLEAR = 32'h34;
  localparam logic [31:0] REG_BUSY       = 32'h38;

endpackage
`default_nettype wire

// File: rtl/apb_master_if.sv
`default_nettype none
// ============================================================================
// Module  : apb_master_if
// Brief   : Command/response and APB3 bus bundle for apb_master.
//           master = initiator view, slave = the CPU model / APB target view.
// Revision: 1.0 - initial release
// ============================================================================
interface apb_master_if
  import apb_pkg::*;
#(
  parameter int ADDR_W = APB_ADDR_W,
  parameter int DATA_W = APB_DATA_W
);
  logic              I_CMD_VALID;
  logic              O_CMD_READY;
  logic              I_CMD_WRITE;
  logic [ADDR_W-1:0] I_CMD_ADDR;
  logic [DATA_W-1:0] I_CMD_WDATA;
  logic              O_RSP_VALID;
  logic [DATA_W-1:0] O_RSP_RDATA;
  logic              O_RSP_ERR;
  logic              O_BUSY;
  logic              O_PSEL;
  logic              O_PENABLE;
  logic              O_PWRITE;
  logic [ADDR_W-1:0] O_PADDR;
  logic [DATA_W-1:0] O_PWDATA;
  logic [DATA_W-1:0] I_PRDATA;
  logic              I_PREADY;

  modport master (
    input  I_CMD_VALID, I_CMD_WRITE, I_CMD_ADDR, I_CMD_WDATA, I_PRDATA, I_PREADY,
    output O_CMD_READY, O_RSP_VALID, O_RSP_RDATA, O_RSP_ERR, O_BUSY,
           O_PSEL, O_PENABLE, O_PWRITE, O_PADDR, O_PWDATA
  );

  modport slave (
    output I_CMD_VALID, I_CMD_WRITE, I_CMD_ADDR, I_CMD_WDATA, I_PRDATA, I_PREADY,
    input  O_CMD_READY, O_RSP_VALID, O_RSP_RDATA, O_RSP_ERR, O_BUSY,
           O_PSEL, O_PENABLE, O_PWRITE, O_PADDR, O_PWDATA
  );
endinterface
`default_nettype wire

// File: rtl/apb_timeout_cnt.sv
`default_nettype none
// ============================================================================
// Module  : apb_timeout_cnt
// Brief   : Clear/enable up-counter with a terminal-count flag, used to bound
//           the number of ACCESS cycles spent waiting for PREADY.
// Revision: 1.0 - initial release
// ============================================================================
module apb_timeout_cnt #(
  parameter int TERMINAL = 15,
  parameter int CNT_W    = 8
) (
  input  wire logic I_PCLK,
  input  wire logic I_PRESET,
  input  wire logic i_clr,
  input  wire logic i_en,
  output logic      o_tc
);
  localparam logic [CNT_W-1:0] c_terminal = CNT_W'(TERMINAL);

  logic [CNT_W-1:0] r_cnt;

  // Count enabled cycles; clear has priority over enable
  always_ff @(posedge I_PCLK) begin
    if (I_PRESET) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tc = (r_cnt == c_terminal);
endmodule
`default_nettype wire

// File: rtl/apb_master.sv
`default_nettype none
// ============================================================================
// Module  : apb_master
// Brief   : Single-outstanding command/response to APB3 initiator with an
//           ACCESS-phase timeout that returns an error response.
// Revision: 1.0 - initial release
// ============================================================================
module apb_master
  import apb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ADDR_W         = APB_ADDR_W,
  parameter int DATA_W         = APB_DATA_W
) (
  input  wire logic    I_PCLK,
  input  wire logic    I_PRESET,
  apb_master_if.master bus
);
  localparam logic [1:0] c_st_idle   = APB_IDLE;
  localparam logic [1:0] c_st_setup  = APB_SETUP;
  localparam logic [1:0] c_st_access = APB_ACCESS;

  // Masking the two low bits forces word alignment of the captured address
  localparam logic [ADDR_W-1:0] c_word_mask = ~ADDR_W'(3);

  logic [1:0]        r_state;
  logic              r_psel;
  logic              r_penable;
  logic              r_pwrite;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_err;
  logic              r_busy;
  logic              w_tc;
  logic              w_cnt_clr;
  logic              w_cnt_en;

  // Counter restarts in SETUP and advances on each ACCESS cycle without PREADY
  assign w_cnt_clr = (r_state == c_st_setup);
  assign w_cnt_en  = (r_state == c_st_access) && !bus.I_PREADY && !w_tc;

  apb_timeout_cnt #(
    .TERMINAL (TIMEOUT_CYCLES - 1),
    .CNT_W    (8)
  ) u_timeout_cnt (
    .I_PCLK   (I_PCLK),
    .I_PRESET (I_PRESET),
    .i_clr    (w_cnt_clr),
    .i_en     (w_cnt_en),
    .o_tc     (w_tc)
  );

  // Transfer FSM and registered bus/response outputs
  always_ff @(posedge I_PCLK) begin
    if (I_PRESET) begin
      r_state     <= c_st_idle;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      case (r_state)
        c_st_idle: begin
          if (bus.I_CMD_VALID) begin
            r_state   <= c_st_setup;
            r_psel    <= 1'b1;
            r_penable <= 1'b0;
            r_busy    <= 1'b1;
            r_pwrite  <= bus.I_CMD_WRITE;
            r_paddr   <= bus.I_CMD_ADDR & c_word_mask;
            r_pwdata  <= bus.I_CMD_WRITE ? bus.I_CMD_WDATA : '0;
          end
        end
        c_st_setup: begin
          r_state   <= c_st_access;
          r_penable <= 1'b1;
        end
        c_st_access: begin
          if (bus.I_PREADY || w_tc) begin
            r_state     <= c_st_idle;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_busy      <= 1'b0;
            r_rsp_valid <= 1'b1;
            // PREADY wins over a coincident timeout
            r_rsp_err   <= !bus.I_PREADY;
            r_rsp_rdata <= (bus.I_PREADY && !r_pwrite) ? bus.I_PRDATA : '0;
          end
        end
        default: begin
          r_state <= c_st_idle;
        end
      endcase
    end
  end

  assign bus.O_CMD_READY = (r_state == c_st_idle) && !I_PRESET;
  assign bus.O_RSP_VALID = r_rsp_valid;
  assign bus.O_RSP_RDATA = r_rsp_rdata;
  assign bus.O_RSP_ERR   = r_rsp_err;
  assign bus.O_BUSY      = r_busy;
  assign bus.O_PSEL      = r_psel;
  assign bus.O_PENABLE   = r_penable;
  assign bus.O_PWRITE    = r_pwrite;
  assign bus.O_PADDR     = r_paddr;
  assign bus.O_PWDATA    = r_pwdata;
endmodule
`default_nettype wire

// File: tb/tb_apb_master.sv
`default_nettype none
// ============================================================================
// Module  : tb_apb_master
// Brief   : Directed self-checking bench for apb_master against a one-wait
//           state rotator register-file slave model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_apb_master;
  import apb_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  apb_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  apb_master #(
    .TIMEOUT_CYCLES (16),
    .ADDR_W         (32),
    .DATA_W         (32)
  ) dut (
    .I_PCLK   (clk),
    .I_PRESET (rst),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rotator slave model: PREADY follows PENABLE by one cycle when enabled
  logic [31:0] regs [16];
  logic        s_ready;
  logic        slave_en;

  always @(posedge clk) begin
    if (rst) s_ready <= 1'b0;
    else     s_ready <= slave_en && bus.O_PSEL && bus.O_PENABLE && !s_ready;
  end

  always @(posedge clk) begin
    if (bus.O_PSEL && bus.O_PENABLE && s_ready && bus.O_PWRITE)
      regs[bus.O_PADDR[5:2]] <= bus.O_PWDATA;
  end

  assign bus.I_PREADY = s_ready;
  assign bus.I_PRDATA = regs[bus.O_PADDR[5:2]];

  // Protocol monitor: PENABLE must never be high without PSEL
  int penable_viol;
  always @(negedge clk) begin
    if (bus.O_PENABLE && !bus.O_PSEL) penable_viol++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One transfer; returns response plus bus observations from SETUP onward
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rdata, output logic err, output int lat,
                      output int acc_cycles, output logic [31:0] s_paddr,
                      output logic [31:0] s_pwdata);
    int   k;
    logic seen;
    logic hold_bad;
    @(negedge clk);
    bus.I_CMD_VALID = 1'b1;
    bus.I_CMD_WRITE = wr;
    bus.I_CMD_ADDR  = addr;
    bus.I_CMD_WDATA = wdata;
    check("cmd_ready", 32'(bus.O_CMD_READY), 32'd1);
    @(negedge clk);
    // Scramble command fields after acceptance; they must be ignored
    bus.I_CMD_VALID = 1'b0;
    bus.I_CMD_WRITE = ~wr;
    bus.I_CMD_ADDR  = $urandom;
    bus.I_CMD_WDATA = $urandom;
    s_paddr    = bus.O_PADDR;
    s_pwdata   = bus.O_PWDATA;
    check("setup_phase", {30'd0, bus.O_PSEL, bus.O_PENABLE}, 32'd2);
    rdata = '0; err = 1'b0; lat = 0; acc_cycles = 0;
    seen = 1'b0; hold_bad = 1'b0; k = 1;
    while (!seen && k <= 40) begin
      if (bus.O_PSEL && (bus.O_PADDR !== s_paddr || bus.O_PWDATA !== s_pwdata ||
                         bus.O_PWRITE !== wr)) hold_bad = 1'b1;
      if (bus.O_PSEL && bus.O_PENABLE) acc_cycles++;
      if (bus.O_RSP_VALID) begin
        seen = 1'b1; lat = k; rdata = bus.O_RSP_RDATA; err = bus.O_RSP_ERR;
      end else begin
        @(negedge clk);
        k++;
      end
    end
    check("rsp_seen", 32'(seen), 32'd1);
    check("apb_hold", 32'(hold_bad), 32'd0);
  endtask

  logic [31:0] rd, spa, spw;
  logic        er;
  int          lat, acc;
  int          idx, nrsp, ready_bad, late_rsp;
  int          rsp_t [3];
  logic [31:0] rsp_d [3];
  logic        rsp_e [3];
  logic        acc_now;

  initial begin
    checks = 0; failures = 0;
    for (int i = 0; i < 16; i++) regs[i] = 32'd0;
    rst = 1'b1; slave_en = 1'b1;
    bus.I_CMD_VALID = 1'b0; bus.I_CMD_WRITE = 1'b0;
    bus.I_CMD_ADDR = '0; bus.I_CMD_WDATA = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_apb", {27'd0, bus.O_PSEL, bus.O_PENABLE, bus.O_PWRITE, bus.O_BUSY,
                      bus.O_CMD_READY}, 32'd0);
    check("rst_paddr", bus.O_PADDR, 32'd0);
    check("rst_pwdata", bus.O_PWDATA, 32'd0);
    check("rst_rsp", {31'd0, bus.O_RSP_VALID | bus.O_RSP_ERR}, 32'd0);
    check("rst_rdata", bus.O_RSP_RDATA, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", 32'(bus.O_CMD_READY), 32'd1);

    // Write then read DMA_SRC
    xfer(1'b1, REG_DMA_SRC, 32'h1234_5678, rd, er, lat, acc, spa, spw);
    check("wr_pwdata", spw, 32'h1234_5678);
    check("wr_lat", 32'(lat), 32'd4);
    check("wr_acc", 32'(acc), 32'd2);
    check("wr_rdata", rd, 32'd0);
    check("wr_err", 32'(er), 32'd0);
    @(negedge clk);
    check("rsp_one_cycle", 32'(bus.O_RSP_VALID), 32'd0);
    xfer(1'b0, REG_DMA_SRC, 32'hFFFF_FFFF, rd, er, lat, acc, spa, spw);
    check("rd_rdata", rd, 32'h1234_5678);
    check("rd_err", 32'(er), 32'd0);
    check("rd_lat", 32'(lat), 32'd4);
    check("rd_pwdata", spw, 32'd0);

    // NEW_H write then readback
    xfer(1'b1, REG_NEW_H, 32'h0000_00F0, rd, er, lat, acc, spa, spw);
    xfer(1'b0, REG_NEW_H, 32'd0, rd, er, lat, acc, spa, spw);
    check("newh_rdata", {16'd0, rd[15:0]}, 32'h0000_00F0);
    check("newh_paddr", spa, 32'h10);

    // Unaligned write address is forced to word alignment
    xfer(1'b1, 32'h0000_0023, 32'hDEAD_BEEF, rd, er, lat, acc, spa, spw);
    check("align_paddr", spa, 32'h0000_0020);

    // Timeout: slave never answers
    slave_en = 1'b0;
    xfer(1'b0, REG_IMG_H, 32'd0, rd, er, lat, acc, spa, spw);
    check("to_acc", 32'(acc), 32'd16);
    check("to_lat", 32'(lat), 32'd18);
    check("to_err", 32'(er), 32'd1);
    check("to_rdata", rd, 32'd0);
    check("to_psel", 32'(bus.O_PSEL), 32'd0);
    slave_en = 1'b1;

    // Back-to-back: VALID held for three commands
    idx = 0; nrsp = 0; ready_bad = 0;
    @(negedge clk);
    bus.I_CMD_VALID = 1'b1; bus.I_CMD_WRITE = 1'b1;
    bus.I_CMD_ADDR = REG_BEF_MASK; bus.I_CMD_WDATA = 32'hAAAA_5555;
    for (int k = 0; k < 40; k++) begin
      if (bus.O_CMD_READY !== !bus.O_BUSY) ready_bad++;
      if (bus.O_RSP_VALID && nrsp < 3) begin
        rsp_t[nrsp] = k; rsp_d[nrsp] = bus.O_RSP_RDATA; rsp_e[nrsp] = bus.O_RSP_ERR;
        nrsp++;
      end
      acc_now = bus.I_CMD_VALID && bus.O_CMD_READY;
      @(negedge clk);
      if (acc_now) begin
        idx++;
        if (idx == 1) begin
          bus.I_CMD_WRITE = 1'b1; bus.I_CMD_ADDR = REG_AFT_MASK;
          bus.I_CMD_WDATA = 32'h0F0F_0F0F;
        end else if (idx == 2) begin
          bus.I_CMD_WRITE = 1'b0; bus.I_CMD_ADDR = REG_BEF_MASK;
          bus.I_CMD_WDATA = 32'h0;
        end else begin
          bus.I_CMD_VALID = 1'b0;
        end
      end
    end
    check("b2b_nrsp", 32'(nrsp), 32'd3);
    check("b2b_ready", 32'(ready_bad), 32'd0);
    if (nrsp == 3) begin
      check("b2b_t0", 32'(rsp_t[0]), 32'd4);
      check("b2b_gap1", 32'(rsp_t[1] - rsp_t[0]), 32'd4);
      check("b2b_gap2", 32'(rsp_t[2] - rsp_t[1]), 32'd4);
      check("b2b_d0", rsp_d[0], 32'd0);
      check("b2b_d2", rsp_d[2], 32'hAAAA_5555);
      check("b2b_err", {29'd0, rsp_e[0], rsp_e[1], rsp_e[2]}, 32'd0);
    end
    check("aft_reg", regs[12], 32'h0F0F_0F0F);

    // Reset during ACCESS
    @(negedge clk);
    bus.I_CMD_VALID = 1'b1; bus.I_CMD_WRITE = 1'b0; bus.I_CMD_ADDR = REG_DMA_SRC;
    @(negedge clk);
    bus.I_CMD_VALID = 1'b0;
    @(negedge clk);
    check("pre_rst_access", {30'd0, bus.O_PSEL, bus.O_PENABLE}, 32'd3);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_apb", {28'd0, bus.O_PSEL, bus.O_PENABLE, bus.O_BUSY, bus.O_CMD_READY}, 32'd0);
    check("midrst_rsp", 32'(bus.O_RSP_VALID), 32'd0);
    rst = 1'b0;
    late_rsp = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.O_RSP_VALID) late_rsp++;
    end
    check("midrst_norsp", 32'(late_rsp), 32'd0);
    xfer(1'b0, REG_DMA_SRC, 32'd0, rd, er, lat, acc, spa, spw);
    check("post_rst_rd", rd, 32'h1234_5678);
    check("post_rst_lat", 32'(lat), 32'd4);

    check("penable_wo_psel", 32'(penable_viol), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
